pc104_adc_reader: RTL

- Clocked PC104/ISA I/O slave that runs an external parallel 16-bit ADC and returns the results to the host over SD.
- The host writes a command to start a conversion on one of 8 mux channels. It then polls status and reads the 16-bit result.
- Read-direction counterpart of the DAC write-strobe decoder on the same PC104 CPLD.
- Shares SA/SD/IOR/IOW with that decoder and uses its own address window at BASE_ADR.

---
 rtl/pc104_adc_reader_if.sv | 23 ++
 rtl/pc104_adc_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc104_adc_reader_if.sv
// ISA host strobes/address plus ADC control lines for pc104_adc_reader.
// SD and IOCS16 are tristate and stay plain ports on the top module.
interface pc104_adc_reader_if;
  logic        IOW;
  logic        IOR;
  logic [11:0] SA;
  logic [2:0]  MUX_SEL;
  logic        ADC_CONVST;
  logic        ADC_BUSY;
  logic        ADC_CS;
  logic        ADC_RD;
  logic [15:0] ADC_D;

  modport slave (
    input  IOW, IOR, SA, ADC_BUSY, ADC_D,
    output MUX_SEL, ADC_CONVST, ADC_CS, ADC_RD
  );

  modport master (
    output IOW, IOR, SA, ADC_BUSY, ADC_D,
    input  MUX_SEL, ADC_CONVST, ADC_CS, ADC_RD
  );
endinterface

// File: rtl/pc104_adc_reader.sv
// PC104 I/O slave that sequences a parallel 16-bit ADC and returns results on SD.
// Optional continuous channel scan is built when AUTO_SCAN_EN is defined.
module pc104_adc_reader #(
  parameter logic [11:0] BASE_ADR     = 12'h220,
  parameter int          SETTLE_CYC   = 8,
  parameter int          CONV_LOW_CYC = 4,
  parameter int          RD_CYC       = 3,
  parameter int          TOUT_CYC     = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  pc104_adc_reader_if.slave    bus,
  inout  wire  [15:0]          SD,
  output wire                  IOCS16,
  output logic [2:0]           fsm_state
);

  localparam int MAX_A   = (SETTLE_CYC > CONV_LOW_CYC) ? SETTLE_CYC : CONV_LOW_CYC;
  localparam int MAX_B   = (RD_CYC > TOUT_CYC) ? RD_CYC : TOUT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CONV_LD   = CW'(CONV_LOW_CYC - 1);
  localparam logic [CW-1:0] RD_LD     = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] TOUT_LD   = CW'(TOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    CONV      = 3'd2,
    WAIT_BUSY = 3'd3,
    READ      = 3'd4,
    DONE_ST   = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    iow_q, ior_q;
  logic [1:0]    busy_q;
  logic [11:0]   rd_adr_q;
  logic [15:0]   data_q;
  logic [2:0]    mux_q;
  logic          done_q, tout_q, ovr_q, seen_high_q;
  logic          scan_bit, scan_go;

  // Host strobes: IOW/IOR are active-low and asynchronous. A command is taken
  // on the synced IOW falling edge using SA/SD as they stand on that cycle;
  // a DATA read is committed (DONE cleared) on the synced IOR rising edge using
  // the address captured at its falling edge.
  logic iow_fall, ior_fall, ior_rise, cmd_wr, start_ok, data_rd_clr, busy_fall;

  assign iow_fall    = iow_q[2] & ~iow_q[1];
  assign ior_fall    = ior_q[2] & ~ior_q[1];
  assign ior_rise    = ~ior_q[2] & ior_q[1];
  assign cmd_wr      = iow_fall && (bus.SA == BASE_ADR);
  assign start_ok    = cmd_wr && SD[7] && (state == IDLE);
  assign data_rd_clr = ior_rise && (rd_adr_q == BASE_ADR + 12'd4);
  assign busy_fall   = (state == WAIT_BUSY) && seen_high_q && !busy_q[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      iow_q    <= 3'b111;
      ior_q    <= 3'b111;
      busy_q   <= 2'b00;
      rd_adr_q <= 12'h000;
    end else begin
      iow_q  <= {iow_q[1:0], bus.IOW};
      ior_q  <= {ior_q[1:0], bus.IOR};
      busy_q <= {busy_q[0], bus.ADC_BUSY};
      if (ior_fall) rd_adr_q <= bus.SA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The counter reloads on every state entry and stops at zero inside a state.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt != '0) ? cnt - 1'b1 : cnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = SETTLE;
          cnt_nx   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nx = CONV;
          cnt_nx   = CONV_LD;
        end
      end
      CONV: begin
        if (cnt == '0) begin
          state_nx = WAIT_BUSY;
          cnt_nx   = TOUT_LD;
        end
      end
      WAIT_BUSY: begin
        if (busy_fall) begin
          state_nx = READ;
          cnt_nx   = RD_LD;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end
      end
      READ: begin
        if (cnt == '0) state_nx = DONE_ST;
      end
      DONE_ST: begin
        if (scan_go) begin
          state_nx = SETTLE;
          cnt_nx   = SETTLE_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mux_q       <= 3'd0;
      data_q      <= 16'h0000;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
      ovr_q       <= 1'b0;
      seen_high_q <= 1'b0;
    end else begin
      if (cmd_wr) begin
        if (SD[7]) begin
          if (state == IDLE) begin
            mux_q  <= SD[2:0];
            done_q <= 1'b0;
            tout_q <= 1'b0;
            ovr_q  <= 1'b0;
          end else begin
            ovr_q <= 1'b1;
          end
        end else if (state == IDLE) begin
          mux_q <= SD[2:0];
        end
      end
      if (state != WAIT_BUSY) seen_high_q <= 1'b0;
      else if (busy_q[1])     seen_high_q <= 1'b1;
      if (state == WAIT_BUSY && !busy_fall && cnt == '0) tout_q <= 1'b1;
      if (state == READ && cnt == '0) data_q <= bus.ADC_D;
      // Clear first so a DONE_ST on the same cycle wins.
      if (data_rd_clr) done_q <= 1'b0;
      if (state == DONE_ST) begin
        done_q <= 1'b1;
        if (scan_go) mux_q <= mux_q + 3'd1;
      end
    end
  end

`ifdef AUTO_SCAN_EN
  logic scan_q, stop_q;
  logic unused_sd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      if (start_ok) begin
        scan_q <= SD[6];
        stop_q <= 1'b0;
      end else if (cmd_wr && !SD[7] && !SD[6]) begin
        stop_q <= 1'b1;
      end
      if (state != IDLE && state_nx == IDLE) begin
        scan_q <= 1'b0;
        stop_q <= 1'b0;
      end
    end
  end

  assign scan_bit  = scan_q;
  assign scan_go   = scan_q && !stop_q;
  assign unused_sd = ^{SD[15:8], SD[5:3]};
`else
  logic unused_sd;

  assign scan_bit  = 1'b0;
  assign scan_go   = 1'b0;
  assign unused_sd = ^{SD[15:8], SD[6:3]};
`endif

  logic        st_sel, dt_sel, rd_sel;
  logic [15:0] status_word, rd_word;

  assign status_word = {8'h00, ovr_q, tout_q, done_q, (state != IDLE), scan_bit, mux_q};
  assign st_sel      = (bus.SA == BASE_ADR + 12'd2);
  assign dt_sel      = (bus.SA == BASE_ADR + 12'd4);
  assign rd_sel      = st_sel | dt_sel;
  assign rd_word     = dt_sel ? data_q : status_word;
  assign SD          = (!bus.IOR && rd_sel) ? rd_word : 16'hzzzz;
  assign IOCS16      = rd_sel ? 1'b0 : 1'bz;

  assign bus.MUX_SEL    = mux_q;
  assign bus.ADC_CONVST = (state != CONV);
  assign bus.ADC_CS     = (state != READ);
  assign bus.ADC_RD     = (state != READ);
  assign fsm_state      = state;

endmodule
